// File: rtl/sc_regshifter_seq.sv
// sc_regshifter_seq: sequenced shift/rotate register, one 1-bit step per clock for a latched amount.
// Latency: word loads on the start edge, N step edges follow, done pulses for one cycle from edge N (edge 0 when N=0).
// Backpressure: none; start is sampled only in IDLE, ignored while busy and never queued. SC_REGSHIFTER_ARITH_EN makes mode 01 arithmetic.
module sc_regshifter_seq #(
  parameter int RegSHIFTER_DATAWIDTH = 8,
  parameter int RegSHIFTER_AMTWIDTH  = 3,
  parameter logic [RegSHIFTER_DATAWIDTH-1:0] RegSHIFTER_RESET_VALUE = '0
) (
  input  logic                            SC_RegSHIFTER_CLOCK_50,
  input  logic                            SC_RegSHIFTER_RESET_InHigh,
  input  logic                            SC_RegSHIFTER_clear_In,
  input  logic                            SC_RegSHIFTER_start_In,
  input  logic [1:0]                      SC_RegSHIFTER_mode_In,
  input  logic [RegSHIFTER_AMTWIDTH-1:0]  SC_RegSHIFTER_amount_In,
  input  logic [RegSHIFTER_DATAWIDTH-1:0] SC_RegSHIFTER_data_In,
  input  logic                            SC_RegSHIFTER_serial_In,
  output logic [RegSHIFTER_DATAWIDTH-1:0] SC_RegSHIFTER_data_OutBUS,
  output logic                            SC_RegSHIFTER_serial_Out,
  output logic                            SC_RegSHIFTER_busy_Out,
  output logic                            SC_RegSHIFTER_done_Out
);

  localparam int W  = RegSHIFTER_DATAWIDTH;
  localparam int AW = RegSHIFTER_AMTWIDTH;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t         state_q;
  logic [W-1:0]   data_q;
  logic [1:0]     mode_q;
  logic [AW-1:0]  cnt_q;
  logic           ser_q;
  logic           done_q;

  // Result of one step on the current register contents
  logic [W-1:0]   step_dat_d;
  logic           step_bit_d;

  // One 1-bit step according to the mode latched at start; the fill bit comes straight from serial_In
  always_comb begin
    step_dat_d = data_q;
    step_bit_d = 1'b0;
    case (mode_q)
      2'b00: begin
        step_dat_d = {data_q[W-2:0], SC_RegSHIFTER_serial_In};
        step_bit_d = data_q[W-1];
      end
      2'b01: begin
`ifdef SC_REGSHIFTER_ARITH_EN
        step_dat_d = {data_q[W-1], data_q[W-1:1]};
`else
        step_dat_d = {SC_RegSHIFTER_serial_In, data_q[W-1:1]};
`endif
        step_bit_d = data_q[0];
      end
      2'b10: begin
        step_dat_d = {data_q[W-2:0], data_q[W-1]};
        step_bit_d = data_q[W-1];
      end
      default: begin
        step_dat_d = {data_q[0], data_q[W-1:1]};
        step_bit_d = data_q[0];
      end
    endcase
  end

  // Control FSM with registered data, serial-out and done; clear outranks start and aborts any operation
  always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
    if (SC_RegSHIFTER_RESET_InHigh) begin
      state_q <= ST_IDLE;
      data_q  <= RegSHIFTER_RESET_VALUE;
      mode_q  <= 2'b00;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (SC_RegSHIFTER_clear_In) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (SC_RegSHIFTER_start_In) begin
            data_q <= SC_RegSHIFTER_data_In;
            mode_q <= SC_RegSHIFTER_mode_In;
            cnt_q  <= SC_RegSHIFTER_amount_In;
            // A zero amount completes on the load edge itself
            if (SC_RegSHIFTER_amount_In == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        default: begin
          data_q <= step_dat_d;
          ser_q  <= step_bit_d;
          cnt_q  <= cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign SC_RegSHIFTER_data_OutBUS = data_q;
  assign SC_RegSHIFTER_serial_Out  = ser_q;
  assign SC_RegSHIFTER_busy_Out    = (state_q == ST_SHIFT);
  assign SC_RegSHIFTER_done_Out    = done_q;

endmodule

// File: tb/tb_sc_regshifter_seq.sv
// tb_sc_regshifter_seq: randomized and directed operations against a closed-form shift/rotate model.
// Expected results are queued at issue time; a monitor pops one entry on every done pulse.
// Clear and reset aborts flush the queue; any done without a queued entry is reported.
module tb_sc_regshifter_seq;
  localparam int W    = 8;
  localparam int AW   = 3;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [AW-1:0] amt = '0;
  logic [W-1:0]  din = '0;
  logic          ser_in = 1'b0;
  logic [W-1:0]  dout;
  logic          ser_out;
  logic          busy;
  logic          done;

  typedef struct {
    logic [W-1:0] dat;
    logic         ser;
    int           n;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic ser_m = 1'b0;

  always #10 clk = ~clk;

  sc_regshifter_seq #(
    .RegSHIFTER_DATAWIDTH(W),
    .RegSHIFTER_AMTWIDTH(AW),
    .RegSHIFTER_RESET_VALUE(8'h00)
  ) dut (
    .SC_RegSHIFTER_CLOCK_50(clk),
    .SC_RegSHIFTER_RESET_InHigh(rst),
    .SC_RegSHIFTER_clear_In(clr),
    .SC_RegSHIFTER_start_In(start),
    .SC_RegSHIFTER_mode_In(mode),
    .SC_RegSHIFTER_amount_In(amt),
    .SC_RegSHIFTER_data_In(din),
    .SC_RegSHIFTER_serial_In(ser_in),
    .SC_RegSHIFTER_data_OutBUS(dout),
    .SC_RegSHIFTER_serial_Out(ser_out),
    .SC_RegSHIFTER_busy_Out(busy),
    .SC_RegSHIFTER_done_Out(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-operation result from plain arithmetic: shift by n with fill bits, rotate by n mod W
  function automatic exp_t model(input logic [W-1:0] dv, input logic [1:0] m, input int n,
                                 input logic f, input logic prev_ser);
    exp_t e;
    int   d;
    int   r;
    int   fill;
    d = int'(dv);
    e.n = n;
    e.dat = dv;
    e.ser = prev_ser;
    if (n != 0) begin
      r = n % W;
      case (m)
        2'b00: begin
          e.dat = W'(((d << n) | (f ? ((1 << n) - 1) : 0)) & MASK);
          e.ser = 1'((d >> (W - n)) & 1);
        end
        2'b01: begin
`ifdef SC_REGSHIFTER_ARITH_EN
          fill = (d >> (W - 1)) & 1;
`else
          fill = int'(f);
`endif
          e.dat = W'(((d >> n) | ((fill != 0) ? ((MASK << (W - n)) & MASK) : 0)) & MASK);
          e.ser = 1'((d >> (n - 1)) & 1);
        end
        2'b10: begin
          e.dat = W'(((d << r) | (d >> (W - r))) & MASK);
          e.ser = e.dat[0];
        end
        default: begin
          e.dat = W'(((d >> r) | (d << (W - r))) & MASK);
          e.ser = e.dat[W-1];
        end
      endcase
    end
    return e;
  endfunction

  // Issue one operation at a negedge; optionally poke a stray start, clear or reset at negedge index i
  task automatic run_op(input logic [W-1:0] d, input logic [1:0] m, input int n, input logic f,
                        input int poke, input int clr_at, input int rst_at);
    exp_t e;
    e = model(d, m, n, f, ser_m);
    din = d; mode = m; amt = AW'(n); ser_in = f; start = 1'b1;
    sb_q.push_back(e);
    ser_m = e.ser;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == poke) begin
        start = 1'b1; din = '1; mode = ~m; amt = '1;
      end
      if (i == clr_at) begin
        clr = 1'b1;
        sb_q.delete();
        ser_m = 1'b0;
        @(posedge clk); #1;
        check("clear_data", 32'(dout), 32'h0);
        check("clear_busy", 32'(busy), 32'h0);
        check("clear_done", 32'(done), 32'h0);
        check("clear_serial", 32'(ser_out), 32'h0);
        @(negedge clk);
        clr = 1'b0;
        return;
      end
      if (i == rst_at) begin
        #3 rst = 1'b1;
        #1;
        check("areset_data", 32'(dout), 32'h0);
        check("areset_busy", 32'(busy), 32'h0);
        check("areset_done", 32'(done), 32'h0);
        check("areset_serial", 32'(ser_out), 32'h0);
        sb_q.delete();
        ser_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (done) return;
    end
    check("op_timeout", 32'h0, 32'h1);
  endtask

  // Monitor: count busy cycles of each operation and score the result on its done pulse
  initial begin
    int   busy_run;
    exp_t e;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 32'h1, 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("result_data", 32'(dout), 32'(e.dat));
          check("result_serial", 32'(ser_out), 32'(e.ser));
          check("busy_cycles", 32'(busy_run), 32'(e.n));
          check("busy_at_done", 32'(busy), 32'h0);
        end
        busy_run = 0;
      end else if (busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end
  end

  initial begin
    #25;
    check("reset_data", 32'(dout), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_serial", 32'(ser_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h81, 2'b10, 3, 1'b0, 0, 0, 0);
    run_op(8'hB5, 2'b00, 1, 1'b1, 0, 0, 0);
    run_op(8'hB5, 2'b00, 2, 1'b1, 0, 0, 0);
    run_op(8'h80, 2'b01, 7, 1'b0, 0, 0, 0);
    run_op(8'h80, 2'b01, 7, 1'b1, 0, 0, 0);
    run_op(8'h5A, 2'b11, 0, 1'b0, 0, 0, 0);
    run_op(8'h0F, 2'b11, 5, 1'b0, 2, 0, 0);
    run_op(8'h0F, 2'b00, 5, 1'b1, 3, 0, 0);
    run_op(8'h3C, 2'b00, 6, 1'b1, 0, 2, 0);
    run_op(8'hC3, 2'b01, 4, 1'b1, 0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      run_op(W'($urandom), 2'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 0, 0, 0);
    end

    run_op(8'hA5, 2'b10, 6, 1'b0, 0, 0, 3);
    run_op(8'h96, 2'b11, 7, 1'b0, 0, 0, 0);
    run_op(8'h01, 2'b10, 0, 1'b0, 0, 0, 0);

    repeat (6) @(negedge clk);
    check("queue_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
